seq_restoring_divider: RTL and testbench

- Multi-cycle unsigned integer divider for the arithmetic datapath.
- Built as the inverse companion of the ripple-carry adder/subtractor: it computes dividend / divisor by repeated trial subtraction, one quotient bit per clock.
- Uses a start/busy/done handshake so a controller can issue operands and collect quotient and remainder.
- Sits beside the add/subtract unit as the divide path of the 4-bit ALU.

---
 rtl/seq_restoring_divider.sv | 114 +++++++++++
 tb/tb_seq_restoring_divider.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, divide-by-zero flagged without entering RUN.
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_next;

    // The partial remainder never exceeds the divisor after restore, so its
    // top bit is always zero between iterations and is not stored.
    logic [WIDTH-1:0] r_reg, r_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             done_next;
    logic [WIDTH-1:0] quo_next, rem_next;
    logic             dbz_next;

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {r_reg, q_reg[WIDTH-1]};
    assign trial   = shifted - {1'b0, d_reg};
    assign busy    = (state == RUN);

    always_comb begin
        state_next = state;
        r_next     = r_reg;
        q_next     = q_reg;
        d_next     = d_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        quo_next   = quotient;
        rem_next   = remainder;
        dbz_next   = div_by_zero;
        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        r_next     = '0;
                        q_next     = dividend;
                        d_next     = divisor;
                        cnt_next   = '0;
                        state_next = RUN;
                    end else begin
                        quo_next  = '1;
                        rem_next  = dividend;
                        dbz_next  = 1'b1;
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!trial[WIDTH]) begin
                    r_next = trial[WIDTH-1:0];
                    q_next = {q_reg[WIDTH-2:0], 1'b1};
                end else begin
                    r_next = shifted[WIDTH-1:0];
                    q_next = {q_reg[WIDTH-2:0], 1'b0};
                end
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST) begin
                    quo_next   = q_next;
                    rem_next   = r_next;
                    dbz_next   = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_next;
            done        <= done_next;
            quotient    <= quo_next;
            remainder   <= rem_next;
            div_by_zero <= dbz_next;
        end
    end

    // Working registers are only meaningful in RUN and are reloaded on entry.
    always_ff @(posedge clk) begin
        r_reg   <= r_next;
        q_reg   <= q_next;
        d_reg   <= d_next;
        cnt_reg <= cnt_next;
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive bench for seq_restoring_divider at WIDTH=4.
module tb_seq_restoring_divider;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start, then wait for done. lat = edges after the start edge
    // until done is visible; bcnt = sampled cycles with busy high.
    task automatic issue(input int a, input int b, output int lat, output int bcnt);
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 50) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic check_result(input string tag, input int a, input int b);
        int eq, er, ez;
        eq = (b == 0) ? 15 : a / b;
        er = (b == 0) ? a : a % b;
        ez = (b == 0) ? 1 : 0;
        chk({tag, "_q"}, int'(quotient), eq);
        chk({tag, "_r"}, int'(remainder), er);
        chk({tag, "_dbz"}, int'(div_by_zero), ez);
    endtask

    initial begin
        int lat, bcnt;
        int a_tab[4] = '{15, 5, 0, 15};
        int b_tab[4] = '{1, 9, 6, 15};
        int q_tab[4] = '{15, 0, 0, 1};
        int r_tab[4] = '{0, 5, 0, 0};

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(quotient), 0);
        chk("rst_r", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);

        // 13 / 3
        issue(13, 3, lat, bcnt);
        chk("d13_3_lat", lat, 4);
        chk("d13_3_busy_cycles", bcnt, 4);
        chk("d13_3_busy_at_done", int'(busy), 0);
        chk("d13_3_q", int'(quotient), 4);
        chk("d13_3_r", int'(remainder), 1);
        chk("d13_3_dbz", int'(div_by_zero), 0);
        tick();
        chk("d13_3_done_pulse", int'(done), 0);
        chk("d13_3_q_hold", int'(quotient), 4);
        chk("d13_3_r_hold", int'(remainder), 1);

        // 7 / 0
        issue(7, 0, lat, bcnt);
        chk("d7_0_lat", lat, 0);
        chk("d7_0_busy_cycles", bcnt, 0);
        chk("d7_0_busy", int'(busy), 0);
        chk("d7_0_q", int'(quotient), 15);
        chk("d7_0_r", int'(remainder), 7);
        chk("d7_0_dbz", int'(div_by_zero), 1);
        tick();
        chk("d7_0_done_pulse", int'(done), 0);
        chk("d7_0_busy_after", int'(busy), 0);

        // Boundary operands
        for (int i = 0; i < 4; i++) begin
            tick();
            issue(a_tab[i], b_tab[i], lat, bcnt);
            chk("bnd_q", int'(quotient), q_tab[i]);
            chk("bnd_r", int'(remainder), r_tab[i]);
            chk("bnd_inv", int'(quotient) * b_tab[i] + int'(remainder), a_tab[i]);
            chk("bnd_rlt", int'(remainder < WIDTH'(b_tab[i])), 1);
        end

        // Start while busy is ignored; start in the done cycle is accepted
        tick();
        dividend = 4'd12; divisor = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dividend = 4'd9; divisor = 4'd2; start = 1'b1;
        tick();
        start = 1'b0; dividend = 4'd0; divisor = 4'd0;
        lat = 2;
        while (!done && lat < 50) begin
            tick();
            lat++;
        end
        chk("busy_ign_lat", lat, 4);
        chk("busy_ign_q", int'(quotient), 2);
        chk("busy_ign_r", int'(remainder), 2);
        issue(9, 2, lat, bcnt);
        chk("b2b_lat", lat, 4);
        chk("b2b_q", int'(quotient), 4);
        chk("b2b_r", int'(remainder), 1);

        // Reset during RUN
        tick();
        dividend = 4'd14; divisor = 4'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_q", int'(quotient), 0);
        chk("mid_rst_r", int'(remainder), 0);
        chk("mid_rst_dbz", int'(div_by_zero), 0);
        bcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            bcnt += int'(done) + int'(busy);
        end
        chk("mid_rst_quiet", bcnt, 0);
        issue(14, 4, lat, bcnt);
        chk("post_rst_lat", lat, 4);
        chk("post_rst_q", int'(quotient), 3);
        chk("post_rst_r", int'(remainder), 2);

        // Exhaustive sweep with random gaps (gap 0 exercises back-to-back)
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int gap;
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) tick();
                issue(a, b, lat, bcnt);
                chk("sw_lat", lat, (b == 0) ? 0 : 4);
                check_result("sw", a, b);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
